pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the 5-bit program counter register of the 32-entry instruction memory.
//  Selects sequential, branch or jump targets each cycle; applies stalls and halt.
//  Drives the PC register input (pc_next) and tracks the current PC value.
//  Sits between decode/execute (redirect sources) and the PC register / instruction fetch.
// PARAMETERS
//  PC_W      5      PC width; PC indexes 2**PC_W word locations
//  RESET_PC  0      PC value loaded on reset
//  RAS_DEPTH 4      return-stack entries (used only with PCSEQ_RAS_EN)
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     asynchronous reset, active low
//  stall       in   1     hold PC (pipeline hazard)
//  br_taken    in   1     conditional branch resolved taken
//  br_target   in   PC_W  branch destination
//  jmp         in   1     unconditional jump
//  jmp_target  in   PC_W  jump destination
//  halt        in   1     enter HALT (halt instruction decoded)
//  resume      in   1     leave HALT
//  pc_next     out  PC_W  value for PC register D input
//  pc_val      out  PC_W  current PC (registered copy)
//  fetch_valid out  1     pc_val is a valid fetch address this cycle
//  pc_wrap     out  1     sticky: sequential increment wrapped 2**PC_W-1 -> 0
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_val=RESET_PC, pc_next=RESET_PC, fetch_valid=0, pc_wrap=0,
//   pending cleared, state=BOOT. Reset mid-operation drops any pending redirect.
//  FSM states: BOOT, RUN, STALL, HALT.
//   BOOT -> RUN after exactly 1 cycle (first fetch at RESET_PC in RUN).
//   RUN -> HALT if halt; RUN -> STALL if stall; else stay RUN.
//   STALL -> HALT if halt; STALL -> RUN when stall=0.
//   HALT -> RUN when resume=1 and halt=0; stall ignored in HALT.
//  fetch_valid=1 in RUN only; 0 in BOOT, STALL, HALT.
//  Next PC priority (RUN): halt (hold) > jmp > br_taken > pending redirect > pc_val+1.
//  Increment modulo 2**PC_W; 31 -> 0 sets pc_wrap (sticky until reset).
//  Redirect while stalled: target latched into pending register (jmp beats br);
//   a later redirect during same stall overwrites. Applied on first RUN cycle, then cleared.
//  Redirect arriving in the same cycle stall rises: latched as pending, PC holds.
//  jmp and br_taken together: jmp wins, branch discarded.
//  HALT: PC holds; redirects ignored and pending cleared; resume continues at pc_val+1.
//  pc_next is combinational from state/inputs; pc_val updates on posedge clk to pc_next.
//  Latency: redirect in RUN at cycle N -> pc_val=target at N+1 with fetch_valid=1.
// CONFIGURATION
//  PCSEQ_RAS_EN defined: adds ports call (in,1), ret (in,1), ras_empty (out,1), ras_full (out,1);
//   call pushes pc_val+1 and jumps to jmp_target; ret pops top as next PC (priority below jmp).
//   Push when full overwrites oldest (circular); pop when empty falls back to pc_val+1.
//   call and ret same cycle: ret pops, call pushes (net depth unchanged); next PC = jmp_target.
//   Reset empties stack (ras_empty=1, ras_full=0).
//  PCSEQ_RAS_EN undefined: no extra ports, no stack logic; behaviour exactly as above.
// STRUCTURE
//  Shared package pc_seq_pkg: PC_W/RESET_PC constants, pcseq_state_t enum {BOOT,RUN,STALL,HALT},
//   next-PC source enum {SRC_HOLD,SRC_SEQ,SRC_JMP,SRC_BR,SRC_PEND,SRC_RAS}.
//  One sub-module: pc_ret_stack (RAS_DEPTH x PC_W circular stack), instantiated only under PCSEQ_RAS_EN.
// TESTING
//  Reset release -> BOOT 1 cycle, then pc_val 0,1,2,3 with fetch_valid=1; pc_val=31 -> 0, pc_wrap=1.
//  pc_val=5, stall 3 cycles with br_taken target=20 in stall cycle 1 -> pc_val holds 5,
//   fetch_valid=0; first RUN cycle pc_val=20.
//  pc_val=8, jmp=1 target=2 and br_taken=1 target=14 same cycle -> pc_val=2 next cycle.
//  halt at pc_val=10, jmp target=3 during HALT, resume -> jmp ignored, pc_val=11 after resume.
//  rst_n low mid-stall with pending redirect -> pc_val=0 immediately, pending lost, BOOT on release.
//  PCSEQ_RAS_EN: call at pc_val=4 target=16, ret at pc_val=18 -> pc_val=5; 5 calls then 5 rets
//   -> 4 valid returns, 5th ret with ras_empty=1 -> sequential increment.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants and enums for the next-PC sequencer and its optional return stack.
package pc_seq_pkg;

    localparam int unsigned DEF_PC_W      = 5;
    localparam int unsigned DEF_RESET_PC  = 0;
    localparam int unsigned DEF_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        HALT
    } pcseq_state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_JMP,
        SRC_BR,
        SRC_PEND,
        SRC_RAS
    } pcseq_src_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ret_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] sp_q;
    logic [PtrW-1:0] sp_inc;
    logic [PtrW-1:0] top_idx;
    logic [CntW-1:0] cnt_q;
    logic            do_pop;

    // sp_q is the next free slot; the top of stack sits one below it.
    assign top_idx = (sp_q == '0) ? LastIdx : sp_q - PtrW'(1);
    assign sp_inc  = (sp_q == LastIdx) ? '0 : sp_q + PtrW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FullCnt);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (push && !do_pop) begin
            sp_q  <= sp_inc;
            cnt_q <= full ? cnt_q : cnt_q + CntW'(1);
        end else if (do_pop && !push) begin
            sp_q  <= top_idx;
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Simultaneous pop+push replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (push && do_pop) begin
            mem_q[top_idx] <= push_data;
        end else if (push) begin
            mem_q[sp_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential / branch / jump selection with stall and halt handling.
// Optional return-address stack enabled by defining PCSEQ_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC
`ifdef PCSEQ_RAS_EN
    , parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            halt,
    input  logic            resume,
`ifdef PCSEQ_RAS_EN
    input  logic            call,
    input  logic            ret,
    output logic            ras_empty,
    output logic            ras_full,
`endif
    output logic [PC_W-1:0] pc_next,
    output logic [PC_W-1:0] pc_val,
    output logic            fetch_valid,
    output logic            pc_wrap
);

    pcseq_state_t    state_q, state_d;
    pcseq_src_t      src;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [PC_W-1:0] pend_q, pend_d;
    logic            pend_v_q, pend_v_d;
    logic            wrap_q, wrap_d;
    logic            jmp_any;
    logic            stalling;

`ifdef PCSEQ_RAS_EN
    logic [PC_W-1:0] ras_top;
    logic            ras_push, ras_pop, ret_hit;

    assign jmp_any = jmp | call;
    assign ret_hit = ret & ~ras_empty;

    pc_ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    assign jmp_any = jmp;
`endif

    assign pc_inc   = pc_q + PC_W'(1);
    assign stalling = ((state_q == RUN) || (state_q == STALL)) && stall && !halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= PC_W'(RESET_PC);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:      state_d = RUN;
            RUN,
            STALL: begin
                if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            HALT:      state_d = (resume && !halt) ? RUN : HALT;
            default:   state_d = BOOT;
        endcase
    end

    always_comb begin
        src         = SRC_HOLD;
        fetch_valid = (state_q == RUN);
`ifdef PCSEQ_RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
`endif
        unique case (state_q)
            RUN: begin
                if (!halt && !stall) begin
                    if (jmp_any) begin
                        src = SRC_JMP;
`ifdef PCSEQ_RAS_EN
                        ras_push = call;
                        ras_pop  = call & ret_hit;
                    end else if (ret) begin
                        // An empty stack falls back to the sequential address.
                        ras_pop = ret_hit;
                        src     = ret_hit ? SRC_RAS : SRC_SEQ;
`endif
                    end else if (br_taken) begin
                        src = SRC_BR;
                    end else if (pend_v_q) begin
                        src = SRC_PEND;
                    end else begin
                        src = SRC_SEQ;
                    end
                end
            end
            STALL: begin
                // Leaving a stall resumes at the held PC unless a redirect is waiting.
                if (!halt && !stall) begin
                    if (jmp) begin
                        src = SRC_JMP;
                    end else if (br_taken) begin
                        src = SRC_BR;
                    end else if (pend_v_q) begin
                        src = SRC_PEND;
                    end
                end
            end
            HALT: begin
                if (resume && !halt) begin
                    src = SRC_SEQ;
                end
            end
            default: src = SRC_HOLD;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src)
            SRC_HOLD: pc_d = pc_q;
            SRC_SEQ:  pc_d = pc_inc;
            SRC_JMP:  pc_d = jmp_target;
            SRC_BR:   pc_d = br_target;
            SRC_PEND: pc_d = pend_q;
`ifdef PCSEQ_RAS_EN
            SRC_RAS:  pc_d = ras_top;
`endif
            default:  pc_d = pc_q;
        endcase
    end

    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        wrap_d   = wrap_q | ((src == SRC_SEQ) && (pc_q == '1));
        if (stalling) begin
            if (jmp) begin
                pend_d   = jmp_target;
                pend_v_d = 1'b1;
            end else if (br_taken) begin
                pend_d   = br_target;
                pend_v_d = 1'b1;
            end
        end else begin
            pend_v_d = 1'b0;
        end
    end

    assign pc_next = pc_d;
    assign pc_val  = pc_q;
    assign pc_wrap = wrap_q;

endmodule
